// File: rtl/tone_seq_ctrl.sv
// tone_seq_ctrl: note sequencer for the frequency-divider tone generator.
// A small note table (divisor, duration) is written while idle. On start,
// entries 0..len-1 are played in order. Each note is a LOAD cycle, a PLAY
// phase of max(dur,1) ticks and a fixed one-tick silent GAP. A one-cycle
// done pulse follows the last note.
//
// Optional build macro: TONE_SEQ_LOOP_EN
//   When defined, adds input 'loop'. It is sampled at the end of the final
//   GAP: loop=1 restarts at entry 0 with no done pulse, and loop=0 finishes
//   normally. When undefined, the port is absent and every sequence ends in
//   DONE.

module tone_seq_ctrl #(
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 100000,
  parameter int DUR_W    = 16,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_100mhz,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [31:0]      wr_div,
  input  logic [DUR_W-1:0] wr_dur,
  input  logic [AW:0]      len,
  input  logic             start,
  input  logic             stop,
`ifdef TONE_SEQ_LOOP_EN
  input  logic             loop,
`endif
  output logic [31:0]      fr_ctr,
  output logic             tone_en,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    cur_idx
);

  // The tick counter only needs to reach TICK_DIV-1.
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_GAP,
    ST_DONE
  } state_t;

  // Note table. It is not reset; its contents persist across sequences.
  logic [31:0]      r_div_mem [DEPTH];
  logic [DUR_W-1:0] r_dur_mem [DEPTH];

  state_t           r_state;
  state_t           w_state_next;
  logic [31:0]      r_fr_ctr;
  logic [31:0]      w_fr_ctr_next;
  logic [AW-1:0]    r_cur_idx;
  logic [AW-1:0]    w_cur_idx_next;
  logic [AW:0]      r_eff_len;
  logic [AW:0]      w_eff_len_next;
  logic [TW-1:0]    r_tick_cnt;
  logic [TW-1:0]    w_tick_next;
  logic [DUR_W-1:0] r_dur_cnt;
  logic [DUR_W-1:0] w_dur_next;

  logic             w_tick_wrap;
  logic             w_last_note;
  logic             w_tbl_we;
  logic [AW:0]      w_len_clamped;
  logic [31:0]      w_rd_div;
  logic [DUR_W-1:0] w_rd_dur;

  assign w_tick_wrap   = (r_tick_cnt == TW'(TICK_DIV - 1));
  assign w_last_note   = ({1'b0, r_cur_idx} == (r_eff_len - (AW+1)'(1)));
  assign w_len_clamped = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;

  // Table writes are accepted only while idle, so a running sequence always
  // plays a stable table.
  assign w_tbl_we = wr_en && (r_state == ST_IDLE);

  // The table read is consumed only in LOAD, where it is captured into the
  // fr_ctr and dur_cnt registers. That capture is the registered read port.
  assign w_rd_div = r_div_mem[r_cur_idx];
  assign w_rd_dur = r_dur_mem[r_cur_idx];

  // Table write port.
  always_ff @(posedge clk_100mhz) begin
    if (w_tbl_we) begin
      r_div_mem[wr_addr] <= wr_div;
      r_dur_mem[wr_addr] <= wr_dur;
    end
  end

  // State and datapath registers with an asynchronous clear.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_fr_ctr   <= '0;
      r_cur_idx  <= '0;
      r_eff_len  <= '0;
      r_tick_cnt <= '0;
      r_dur_cnt  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_fr_ctr   <= w_fr_ctr_next;
      r_cur_idx  <= w_cur_idx_next;
      r_eff_len  <= w_eff_len_next;
      r_tick_cnt <= w_tick_next;
      r_dur_cnt  <= w_dur_next;
    end
  end

  // Next-state logic and datapath updates. Stop overrides every busy state.
  always_comb begin
    w_state_next   = r_state;
    w_fr_ctr_next  = r_fr_ctr;
    w_cur_idx_next = r_cur_idx;
    w_eff_len_next = r_eff_len;
    w_tick_next    = r_tick_cnt;
    w_dur_next     = r_dur_cnt;

    case (r_state)
      ST_IDLE: begin
        if (start && !stop) begin
          w_eff_len_next = w_len_clamped;
          w_cur_idx_next = '0;
          w_tick_next    = '0;
          w_dur_next     = '0;
          if (w_len_clamped == '0) begin
            w_fr_ctr_next = '0;
            w_state_next  = ST_DONE;
          end else begin
            w_state_next  = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        // A zero duration still plays for one tick.
        w_fr_ctr_next = w_rd_div;
        w_dur_next    = (w_rd_dur == '0) ? DUR_W'(1) : w_rd_dur;
        w_tick_next   = '0;
        w_state_next  = ST_PLAY;
      end

      ST_PLAY: begin
        if (w_tick_wrap) begin
          w_tick_next = '0;
          w_dur_next  = r_dur_cnt - DUR_W'(1);
          if (r_dur_cnt == DUR_W'(1)) begin
            w_state_next = ST_GAP;
          end
        end else begin
          w_tick_next = r_tick_cnt + TW'(1);
        end
      end

      ST_GAP: begin
        if (w_tick_wrap) begin
          w_tick_next = '0;
          if (w_last_note) begin
`ifdef TONE_SEQ_LOOP_EN
            if (loop) begin
              w_cur_idx_next = '0;
              w_state_next   = ST_LOAD;
            end else begin
              w_cur_idx_next = '0;
              w_fr_ctr_next  = '0;
              w_state_next   = ST_DONE;
            end
`else
            w_cur_idx_next = '0;
            w_fr_ctr_next  = '0;
            w_state_next   = ST_DONE;
`endif
          end else begin
            w_cur_idx_next = r_cur_idx + AW'(1);
            w_state_next   = ST_LOAD;
          end
        end else begin
          w_tick_next = r_tick_cnt + TW'(1);
        end
      end

      ST_DONE: begin
        w_fr_ctr_next  = '0;
        w_cur_idx_next = '0;
        w_state_next   = ST_IDLE;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // Abort: return to IDLE with silent, cleared outputs and no done pulse.
    if (stop && (r_state != ST_IDLE)) begin
      w_state_next   = ST_IDLE;
      w_fr_ctr_next  = '0;
      w_cur_idx_next = '0;
      w_tick_next    = '0;
      w_dur_next     = '0;
    end
  end

  // Outputs. tone_en and done are decoded from the registered state, so
  // they also clear the moment rst_n falls.
  assign fr_ctr  = r_fr_ctr;
  assign tone_en = (r_state == ST_PLAY) && (r_fr_ctr != '0);
  assign busy    = (r_state != ST_IDLE);
  assign done    = (r_state == ST_DONE);
  assign cur_idx = r_cur_idx;

endmodule

// File: tb/tb_tone_seq_ctrl.sv
// Directed bench for tone_seq_ctrl with TICK_DIV=4 and DEPTH=16. Expected
// per-cycle outputs come from a note schedule built from the bench's copy
// of the table.
module tb_tone_seq_ctrl;
  localparam int TICK  = 4;
  localparam int DEPTH = 16;
  localparam int DW    = 16;

  typedef logic [38:0] obs_t;  // {busy, tone_en, done, cur_idx[3:0], fr_ctr[31:0]}

  logic          clk_100mhz = 1'b0;
  logic          rst_n      = 1'b0;
  logic          wr_en      = 1'b0;
  logic [3:0]    wr_addr    = '0;
  logic [31:0]   wr_div     = '0;
  logic [DW-1:0] wr_dur     = '0;
  logic [4:0]    len        = '0;
  logic          start      = 1'b0;
  logic          stop       = 1'b0;
`ifdef TONE_SEQ_LOOP_EN
  logic          loop       = 1'b0;
`endif
  logic [31:0]   fr_ctr;
  logic          tone_en;
  logic          busy;
  logic          done;
  logic [3:0]    cur_idx;

  int total = 0;
  int bad   = 0;
  int busy_seen;
  int done_seen;

  logic [31:0]   m_div [DEPTH];
  logic [DW-1:0] m_dur [DEPTH];
  obs_t          exp_q [$];

  tone_seq_ctrl #(.DEPTH(DEPTH), .TICK_DIV(TICK), .DUR_W(DW)) dut (
    .clk_100mhz (clk_100mhz),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_div     (wr_div),
    .wr_dur     (wr_dur),
    .len        (len),
    .start      (start),
    .stop       (stop),
`ifdef TONE_SEQ_LOOP_EN
    .loop       (loop),
`endif
    .fr_ctr     (fr_ctr),
    .tone_en    (tone_en),
    .busy       (busy),
    .done       (done),
    .cur_idx    (cur_idx)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  function automatic obs_t obs();
    return {busy, tone_en, done, cur_idx, fr_ctr};
  endfunction

  function automatic obs_t mk(input logic b, input logic t, input logic d,
                              input int idx, input logic [31:0] fr);
    return {b, t, d, 4'(idx), fr};
  endfunction

  task automatic chk(input string tag, input obs_t o, input obs_t e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic chk_int(input string tag, input int o, input int e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic wr(input int a, input logic [31:0] dv, input logic [DW-1:0] du);
    @(negedge clk_100mhz);
    wr_en = 1'b1; wr_addr = 4'(a); wr_div = dv; wr_dur = du;
    m_div[a] = dv; m_dur[a] = du;
    @(negedge clk_100mhz);
    wr_en = 1'b0;
  endtask

  // Expected outputs, one entry per cycle from the LOAD cycle onward:
  // LOAD, max(dur,1)*TICK PLAY cycles, TICK GAP cycles per note, then DONE
  // and two idle cycles.
  task automatic build(input int n);
    logic [31:0] prev;
    int d;
    exp_q.delete();
    prev = '0;
    for (int i = 0; i < n; i++) begin
      d = (m_dur[i] == 0) ? 1 : int'(m_dur[i]);
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, i, prev));
      for (int c = 0; c < d * TICK; c++)
        exp_q.push_back(mk(1'b1, m_div[i] != 0, 1'b0, i, m_div[i]));
      for (int c = 0; c < TICK; c++)
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, i, m_div[i]));
      prev = m_div[i];
    end
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 0, 32'd0));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 0, 32'd0));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 0, 32'd0));
  endtask

  // Pulse start with length l, then compare every cycle against exp_q.
  // Optional side actions at cycle k: a table write attempt (wr_at), a
  // second start (start_at) or a stop (stop_at, which ends the run).
  task automatic run(input string tag, input logic [4:0] l,
                     input int wr_at, input int start_at, input int stop_at);
    busy_seen = 0;
    done_seen = 0;
    @(negedge clk_100mhz);
    len = l; start = 1'b1;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk_100mhz);
      chk($sformatf("%s[%0d]", tag, k), obs(), exp_q[k]);
      busy_seen += int'(busy);
      done_seen += int'(done);
      start = (k == start_at);
      wr_en = (k == wr_at);
      if (k == wr_at) begin
        wr_addr = 4'd0; wr_div = 32'd1234; wr_dur = 16'd5;
      end
      stop = (k == stop_at);
      if (k == stop_at) begin
        @(negedge clk_100mhz);
        stop = 1'b0;
        for (int j = 0; j < 4; j++) begin
          chk($sformatf("%s_after_stop[%0d]", tag, j), obs(), '0);
          @(negedge clk_100mhz);
        end
        return;
      end
    end
  endtask

  initial begin
    // Reset state while rst_n is held low.
    repeat (2) @(negedge clk_100mhz);
    chk("reset", obs(), '0);
    rst_n = 1'b1;

    wr(0, 32'd1000, 16'd2);
    wr(1, 32'd0,    16'd1);
    wr(2, 32'd500,  16'd3);

    // Reset asserted between clock edges mid-PLAY clears outputs at once.
    @(negedge clk_100mhz);
    len = 5'd1; start = 1'b1;
    @(negedge clk_100mhz);
    start = 1'b0;
    repeat (3) @(negedge clk_100mhz);
    chk("pre_reset_play", obs(), mk(1'b1, 1'b1, 1'b0, 0, 32'd1000));
    #2 rst_n = 1'b0;
    #1 chk("async_reset", obs(), '0);
    @(negedge clk_100mhz);
    rst_n = 1'b1;

    // Single note after reset.
    build(1);
    run("len1", 5'd1, -1, -1, -1);
    chk_int("len1_busy_cycles", busy_seen, 1 + 8 + 4 + 1);

    // Three-note sequence including a rest.
    build(3);
    run("len3", 5'd3, -1, -1, -1);
    chk_int("len3_busy_cycles", busy_seen, 40);
    chk_int("len3_done_pulses", done_seen, 1);

    // Zero duration plays as one tick.
    wr(0, 32'd700, 16'd0);
    build(1);
    run("dur0", 5'd1, -1, -1, -1);
    chk_int("dur0_busy_cycles", busy_seen, 1 + 4 + 4 + 1);
    wr(0, 32'd1000, 16'd2);

    // len=0 goes straight to DONE.
    build(0);
    run("len0", 5'd0, -1, -1, -1);
    chk_int("len0_done_pulses", done_seen, 1);

    // Stop during note 1, with a table write attempted during PLAY.
    build(3);
    run("stop", 5'd3, 3, -1, 16);
    chk_int("stop_no_done", done_seen, 0);

    // Replay: entry 0 must still hold 1000/2.
    build(1);
    run("replay", 5'd1, -1, -1, -1);

    // start and stop together in IDLE: stay idle.
    @(negedge clk_100mhz);
    len = 5'd3; start = 1'b1; stop = 1'b1;
    @(negedge clk_100mhz);
    start = 1'b0; stop = 1'b0;
    chk("start_stop_idle0", obs(), '0);
    @(negedge clk_100mhz);
    chk("start_stop_idle1", obs(), '0);

    // len=20 clamps to 16 notes; a start during PLAY is ignored.
    for (int i = 3; i < DEPTH; i++) wr(i, 32'(100 + i), 16'd1);
    build(16);
    run("len20", 5'd20, -1, 5, -1);
    chk_int("len20_busy_cycles", busy_seen, 13 + 9 + 17 + 13 * 9 + 1);
    chk_int("len20_done_pulses", done_seen, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tone_seq_ctrl.md
Name: tone_seq_ctrl

Overview:
- Note sequencer driving the frequency-divider tone generator.
- Holds a small writable table of notes (divisor, duration); on start, plays entries 0..len-1 in order.
- Presents one divisor plus a tone enable per note, with a fixed silent gap between notes.
- Sits between the bus/config logic and the divider; asserts done when the sequence completes.

Parameters:
- DEPTH, 16, note table entries (power of two; address width AW = log2(DEPTH)).
- TICK_DIV, 100000, clk_100mhz cycles per duration tick (1 ms at 100 MHz).
- DUR_W, 16, width of per-note duration field, in ticks.

Ports:
- clk_100mhz  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  table write strobe
- wr_addr  in  AW  table write index
- wr_div  in  32  divisor for entry; 0 = rest
- wr_dur  in  DUR_W  note length in ticks
- len  in  AW+1  notes to play, sampled on start
- start  in  1  single-cycle start request
- stop  in  1  abort request
- fr_ctr  out  32  divisor to frequency divider
- tone_en  out  1  divider enable (level)
- busy  out  1  high in any state but IDLE
- done  out  1  one-cycle completion pulse
- cur_idx  out  AW  index of entry being played

Behaviour:
- Reset (async, rst_n=0): state IDLE; fr_ctr=0, tone_en=0, busy=0, done=0, cur_idx=0; tick/duration counters 0. Table contents are not reset.
- Table writes:
  - Writes with wr_en=1 take effect at the clock edge, in IDLE only.
  - Writes while busy are ignored.
- States:
  - IDLE:
    - start=1 and stop=0 -> LOAD. Latch eff_len = min(len, DEPTH).
    - If len=0 -> DONE directly.
  - LOAD (1 cycle):
    - Read entry cur_idx.
    - Register fr_ctr = div.
    - Set dur_cnt = max(dur,1) and clear tick counter.
    - -> PLAY.
  - PLAY:
    - tone_en = (fr_ctr != 0).
    - Tick counter counts 0..TICK_DIV-1; at wrap, dur_cnt decrements.
    - When dur_cnt=1 and tick wraps -> GAP. PLAY therefore lasts exactly max(dur,1)*TICK_DIV cycles.
  - GAP:
    - tone_en=0; fr_ctr holds; lasts exactly TICK_DIV cycles.
    - At end: if cur_idx = eff_len-1 -> DONE; else increment cur_idx and -> LOAD.
  - DONE (1 cycle):
    - done=1, tone_en=0, fr_ctr=0, cur_idx=0.
    - -> IDLE.
- Latency:
  - start sampled at edge T: LOAD during T+1; fr_ctr/tone_en valid from T+2.
  - Per-note period: 1 + dur*TICK_DIV + TICK_DIV cycles.
- Stop:
  - stop=1 in any non-IDLE state: next state IDLE, tone_en=0, fr_ctr=0, cur_idx=0, no done pulse.
  - stop and start in the same cycle in IDLE: stay IDLE.
- start while busy: ignored.
- len > DEPTH: clamped to DEPTH.
- Counters never wrap past their terminal values; widths are sized for TICK_DIV-1 and 2^DUR_W-1.

Optional Feature:
- Macro TONE_SEQ_LOOP_EN.
- Defined:
  - Adds input port loop (1 bit), sampled at the end of the final GAP.
  - loop=1: cur_idx returns to 0 -> LOAD, with no done pulse.
  - loop=0: -> DONE as normal.
  - stop still aborts immediately.
- Undefined: port absent; sequence always terminates in DONE.

Test Plan (TICK_DIV=4, DEPTH=16):
- Reset mid-PLAY: assert rst_n=0 -> all outputs 0 combinationally-async. Release, start len=1 -> plays entry 0 normally.
- Write e0=(div 1000, dur 2), e1=(div 0, dur 1), e2=(div 500, dur 3); start len=3 ->
  - fr_ctr=1000, tone_en=1 for 8 cycles, then 4 gap cycles.
  - fr_ctr=0, tone_en=0 for 4+4 cycles.
  - fr_ctr=500 for 12 cycles, then gap.
  - done pulses once; busy total = 3 + 8+4+4+4+12+4 + 1 = 40 cycles.
- Entry dur=0, len=1 -> plays 4 cycles (treated as 1 tick). len=0 -> done pulse 1 cycle after start, tone_en never high.
- stop asserted 5 cycles into note 1 -> next cycle busy=0, tone_en=0, fr_ctr=0, no done. Write to e0 during PLAY -> table unchanged on replay.
- len=20 -> exactly 16 notes played, cur_idx 0..15. start during PLAY ignored; start+stop same cycle in IDLE -> busy stays 0.
- TONE_SEQ_LOOP_EN defined, loop=1, len=2 -> cur_idx sequence 0,1,0,1… with no done. Drop loop before the end of the final gap -> single done pulse, then IDLE.
